// File: rtl/quad_encoder_counter.sv
// Quadrature encoder position counter.
// Both encoder channels are synchronized, glitch-filtered and decoded into a
// wrapping 32-bit signed position, with snapshot capture and a sticky error
// flag for illegal A/B transitions.
// Optional feature: define QUAD_VELOCITY_EN to build the velocity window
// (count delta per VEL_PERIOD cycles); otherwise vel/vel_valid are tied to 0.
module quad_encoder_counter #(
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned VEL_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] count,
  output logic [31:0] count_snap,
  output logic        snap_valid,
  output logic        err,
  output logic [31:0] vel,
  output logic        vel_valid
);

  localparam int unsigned FW = 8;
  localparam logic [FW:0] FILT_THR = (FW+1)'(FILT_LEN);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  // Elaboration-time guard on the legal parameter ranges
  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
    $error("FILT_LEN out of range 1..255");
  end
  if (VEL_PERIOD < 2 || VEL_PERIOD > (1 << 24)) begin : g_bad_vel_period
    $error("VEL_PERIOD out of range 2..2^24");
  end

  // Map a {A,B} code onto its position in the quadrature cycle 00,01,11,10
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Bit 1 carries channel A, bit 0 carries channel B throughout
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
  state_t              state_q, state_d;
  logic [1:0]          prev_ab_q, prev_ab_d;
  logic [FW-1:0]       stab_q, stab_d;
  logic signed [31:0]  count_q, count_d;
  logic        [31:0]  count_snap_q, count_snap_d;
  logic                snap_valid_q, snap_valid_d;
  logic                err_q, err_d;
  logic signed [31:0]  step;
  logic                illegal;
  logic [1:0]          pos_diff;

  // Two-flop synchronizer inputs
  always_comb begin
    sync1_d = {enc_a, enc_b};
    sync2_d = sync1_q;
  end

  // Per-channel filter: accept a new level only after FILT_LEN consecutive
  // disagreeing samples; any agreeing sample restarts the qualification
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (({1'b0, fcnt_q[i]} + 9'd1) >= FILT_THR) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  // Decoder FSM: wait for settled inputs in INIT, then count steps in TRACK
  always_comb begin
    state_d   = state_q;
    prev_ab_d = prev_ab_q;
    stab_d    = stab_q;
    err_d     = err_q;
    step      = '0;
    illegal   = 1'b0;
    pos_diff  = gray_pos(filt_q) - gray_pos(prev_ab_q);
    case (state_q)
      S_INIT: begin
        prev_ab_d = filt_q;
        // Stable means no pending disagreement anywhere in the input path
        if (filt_q == prev_ab_q && sync1_q == filt_q && sync2_q == filt_q) begin
          if (({1'b0, stab_q} + 9'd1) >= FILT_THR) begin
            state_d = S_TRACK;
            stab_d  = '0;
          end else begin
            stab_d = stab_q + 8'd1;
          end
        end else begin
          stab_d = '0;
        end
      end
      S_TRACK: begin
        prev_ab_d = filt_q;
        case (pos_diff)
          2'd1:    step = 32'sd1;
          2'd3:    step = -32'sd1;
          2'd2:    illegal = 1'b1;
          default: step = '0;
        endcase
      end
      default: state_d = S_INIT;
    endcase
    // clr discards any same-cycle step; an illegal transition still sets err
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      count_d = count_q + step;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  // Snapshot of the pre-update count register
  always_comb begin
    count_snap_d = snap ? count_q : count_snap_q;
    snap_valid_d = snap;
  end

  // State registers for synchronizer, filters, decoder and snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      fcnt_q       <= '0;
      state_q      <= S_INIT;
      prev_ab_q    <= '0;
      stab_q       <= '0;
      count_q      <= '0;
      count_snap_q <= '0;
      snap_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      prev_ab_q    <= prev_ab_d;
      stab_q       <= stab_d;
      count_q      <= count_d;
      count_snap_q <= count_snap_d;
      snap_valid_q <= snap_valid_d;
      err_q        <= err_d;
    end
  end

  assign count      = count_q;
  assign count_snap = count_snap_q;
  assign snap_valid = snap_valid_q;
  assign err        = err_q;

`ifdef QUAD_VELOCITY_EN
  localparam int unsigned WW = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(VEL_PERIOD - 1);

  logic [WW-1:0]      win_q, win_d;
  logic signed [31:0] base_q, base_d;
  logic signed [31:0] vel_q, vel_d;
  logic               vel_valid_q, vel_valid_d;

  // Window counter; at wrap publish the count delta since the previous wrap
  always_comb begin
    win_d       = win_q + 1'b1;
    base_d      = base_q;
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    if (clr) begin
      win_d  = '0;
      base_d = '0;
    end else if (win_q == WIN_LAST) begin
      win_d       = '0;
      vel_d       = count_q - base_q;
      base_d      = count_q;
      vel_valid_d = 1'b1;
    end
  end

  // Velocity registers
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q       <= '0;
      base_q      <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      base_q      <= base_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign vel       = vel_q;
  assign vel_valid = vel_valid_q;
`else
  assign vel       = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Testbench for quad_encoder_counter: table-driven scenarios, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_quad_encoder_counter;

  localparam int F  = 4;
  localparam int VP = 37;

  logic        clk = 1'b0;
  logic        reset, enc_a, enc_b, clr, snap;
  logic [31:0] count, count_snap, vel;
  logic        snap_valid, err, vel_valid;

  always #5 clk = ~clk;

  quad_encoder_counter #(.FILT_LEN(F), .VEL_PERIOD(VP)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .snap(snap), .count(count), .count_snap(count_snap),
    .snap_valid(snap_valid), .err(err), .vel(vel), .vel_valid(vel_valid)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [1:0]  hist[$];
  logic [1:0]  m_filt, m_prev;
  bit          m_track;
  logic [31:0] m_count, m_snap, m_vel, m_base;
  logic        m_err, m_sv, m_vv;
  int          m_win;

  function automatic int qpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] qcode(input int p);
    case (((p % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < F + 4; k++) hist.push_back(2'b00);
    m_filt = 2'b00; m_prev = 2'b00; m_track = 0;
    m_count = '0; m_snap = '0; m_vel = '0; m_base = '0;
    m_err = 1'b0; m_sv = 1'b0; m_vv = 1'b0; m_win = 0;
  endtask

  // One clock: advance the model with the inputs seen at this edge, then compare
  task automatic tick();
    logic [31:0] old_count;
    int          d;
    bit          illegal;
    bit          all_diff;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      old_count = m_count;
      hist.push_front({enc_a, enc_b});
      void'(hist.pop_back());
      illegal = 0;
      d = 0;
      if (m_track) begin
        d = (qpos(m_filt) - qpos(m_prev) + 4) % 4;
        if (d == 2) illegal = 1;
        m_prev = m_filt;
      end
      if (clr) m_count = '0;
      else if (d == 1) m_count = m_count + 32'd1;
      else if (d == 3) m_count = m_count - 32'd1;
      m_err = (m_err & ~clr) | illegal;
      m_sv = snap;
      if (snap) m_snap = old_count;
`ifdef QUAD_VELOCITY_EN
      if (clr) begin
        m_win = 0; m_base = '0; m_vv = 1'b0;
      end else if (m_win == VP - 1) begin
        m_vel = old_count - m_base; m_base = old_count; m_win = 0; m_vv = 1'b1;
      end else begin
        m_win++; m_vv = 1'b0;
      end
`endif
      // A channel flips once its last F synchronized samples all disagree
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = 1;
        for (int k = 2; k < F + 2; k++)
          if (hist[k][ch] == m_filt[ch]) all_diff = 0;
        if (all_diff) m_filt[ch] = ~m_filt[ch];
      end
    end
    #1;
    chk32("count", count, m_count);
    chk1("err", err, m_err);
    chk32("count_snap", count_snap, m_snap);
    chk1("snap_valid", snap_valid, m_sv);
    chk32("vel", vel, m_vel);
    chk1("vel_valid", vel_valid, m_vv);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
  endtask

  task automatic settle_and_track();
    repeat (20) tick();
    m_track = 1;
    m_prev  = m_filt;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  ab;
    int          hold;
    bit          do_clr;
    logic [31:0] exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vt[14];
  logic [1:0] cur;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"fwd1",   2'b10, 10, 0, 32'd1, 1'b0};
    vt[1]  = '{"fwd2",   2'b00, 10, 0, 32'd2, 1'b0};
    vt[2]  = '{"fwd3",   2'b01, 10, 0, 32'd3, 1'b0};
    vt[3]  = '{"fwd4",   2'b11, 10, 0, 32'd4, 1'b0};
    vt[4]  = '{"fwd5",   2'b10, 10, 0, 32'd5, 1'b0};
    vt[5]  = '{"fwd6",   2'b00, 10, 0, 32'd6, 1'b0};
    vt[6]  = '{"fwd7",   2'b01, 10, 0, 32'd7, 1'b0};
    vt[7]  = '{"fwd8",   2'b11, 10, 0, 32'd8, 1'b0};
    vt[8]  = '{"glitch", 2'b01,  3, 0, 32'd8, 1'b0};
    vt[9]  = '{"unglit", 2'b11, 12, 0, 32'd8, 1'b0};
    vt[10] = '{"dual",   2'b00, 12, 0, 32'd8, 1'b1};
    vt[11] = '{"clr",    2'b00, 10, 1, 32'd0, 1'b0};
    vt[12] = '{"rev0",   2'b10, 10, 0, 32'hFFFF_FFFF, 1'b0};
    vt[13] = '{"fwdback",2'b00, 10, 0, 32'd0, 1'b0};

    model_reset();
    reset = 1'b1; clr = 1'b0; snap = 1'b0; set_ab(2'b00);
    repeat (3) tick();
    chk32("reset_count", count, 32'd0);
    chk1("reset_err", err, 1'b0);
    reset = 1'b0;

    // Settle at A=1,B=1 and enter tracking
    set_ab(2'b11);
    settle_and_track();
    chk32("init_count", count, 32'd0);
    chk1("init_err", err, 1'b0);

    // Table-driven scenarios
    for (int i = 0; i < 14; i++) begin
      set_ab(vt[i].ab);
      clr = vt[i].do_clr;
      tick();
      clr = 1'b0;
      repeat (vt[i].hold - 1) tick();
      chk32({vt[i].name, "_count"}, count, vt[i].exp_count);
      chk1({vt[i].name, "_err"}, err, vt[i].exp_err);
    end

    // Latency: count moves on exactly the 7th edge after the input change
    set_ab(2'b01);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk32("latency", count, (i < 7) ? 32'd0 : 32'd1);
    end
    repeat (3) tick();

    // Wrap at the positive limit
    force dut.count_q = 32'h7FFF_FFFF;
    #1;
    release dut.count_q;
    m_count = 32'h7FFF_FFFF;
    set_ab(2'b11);
    repeat (10) tick();
    chk32("wrap_pos", count, 32'h8000_0000);

    // Snapshot coinciding with a step from count=5
    clr = 1'b1; tick(); clr = 1'b0;
    for (int p = 3; p <= 7; p++) begin
      set_ab(qcode(p));
      repeat (10) tick();
    end
    chk32("pre_snap", count, 32'd5);
    set_ab(qcode(8));
    repeat (6) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk32("snap_val", count_snap, 32'd5);
    chk1("snap_pulse", snap_valid, 1'b1);
    chk32("snap_cnt", count, 32'd6);
    tick();
    chk1("snap_pulse_end", snap_valid, 1'b0);

    // Back-to-back snaps
    snap = 1'b1;
    tick();
    chk1("b2b_pulse1", snap_valid, 1'b1);
    tick();
    snap = 1'b0;
    chk1("b2b_pulse2", snap_valid, 1'b1);
    chk32("b2b_val", count_snap, 32'd6);
    tick();
    chk1("b2b_end", snap_valid, 1'b0);

    // Reset mid-qualification with a snap pending
    set_ab(qcode(9));
    repeat (4) tick();
    snap = 1'b1;
    tick();
    reset = 1'b1;
    snap  = 1'b0;
    tick();
    chk1("rst_sv", snap_valid, 1'b0);
    chk32("rst_count", count, 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    chk32("post_rst_count", count, 32'd0);
    cur = qcode(9);
    settle_and_track();

    // Randomized stimulus against the model
    for (int it = 0; it < 250; it++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 12);
      if (r < 4)       set_ab(qcode(qpos(cur) + 1));
      else if (r < 7)  set_ab(qcode(qpos(cur) - 1));
      else if (r == 7) set_ab(qcode(qpos(cur) + 2));
      else             set_ab(cur);
      if (hold > F + 1 || r > 7) cur = {enc_a, enc_b};
      for (int c = 0; c < hold; c++) begin
        clr  = ($urandom_range(0, 19) == 0);
        snap = ($urandom_range(0, 7) == 0);
        tick();
      end
      clr = 1'b0; snap = 1'b0;
      if (hold <= F + 1 && r <= 7) begin
        set_ab(cur);
        repeat (F + 4) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
